// File: rtl/pattern_tx_311_pkg.sv
// Shared encodings and sizing for the pattern transmitter.
package pattern_pkg_311;

  localparam int unsigned WIDTH_DEF = 8;
  localparam int unsigned CNT_W     = 4;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_SHIFT = 2'b01;
  localparam logic [1:0] ST_DONE  = 2'b10;

  // Zero or over-long lengths fall back to the full pattern width.
  function automatic logic [CNT_W-1:0] eff_len(input logic [3:0] len,
                                               input int unsigned width);
    if (len == 4'd0 || 32'(len) > width) return CNT_W'(width);
    return CNT_W'(len);
  endfunction

endpackage

// File: rtl/pattern_tx_311_if.sv
// Request/serial-output bundle between a pattern source and the transmitter.
interface pattern_tx_311_if #(
  parameter int unsigned WIDTH = pattern_pkg_311::WIDTH_DEF
) ();

  logic             start_311;
  logic [WIDTH-1:0] data_311;
  logic [3:0]       len_311;
  logic             rep_311;
  logic             out_311;
  logic             vld_311;
  logic             busy_311;
  logic             done_311;

  modport master (
    output start_311, data_311, len_311, rep_311,
    input  out_311, vld_311, busy_311, done_311
  );

  modport slave (
    input  start_311, data_311, len_311, rep_311,
    output out_311, vld_311, busy_311, done_311
  );

endinterface

// File: rtl/pattern_tx_311_bit_cnt.sv
// Loadable down-counter tracking how many pattern bits remain.
module bit_cnt_311
  import pattern_pkg_311::*;
(
  input  logic             clk_311,
  input  logic             rst_311,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             last_c
);

  // Load wins over decrement; reset clears the count.
  always_ff @(posedge clk_311) begin
    if (rst_311)   cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec)  cnt <= cnt - CNT_W'(1);
  end

  assign last_c = (cnt == CNT_W'(1));

endmodule

// File: rtl/pattern_tx_311.sv
// Serial pattern transmitter: MSB-first, optional gapless repeat, done pulse.
module pattern_tx_311
  import pattern_pkg_311::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk_311,
  input  logic             rst_311,
  pattern_tx_311_if.slave  bus
);

  logic [1:0]       state, state_nxt;
  logic [WIDTH-1:0] pat_q, pat_nxt;   // captured pattern, MSB-aligned
  logic [WIDTH-1:0] sr_q, sr_nxt;     // bits still to be sent, MSB next
  logic [CNT_W-1:0] len_q, len_nxt;
  logic             rep_q, rep_nxt;
  logic             out_nxt, vld_nxt, busy_nxt, done_nxt;

  logic             cnt_load, cnt_dec, cnt_last_c;
  logic [CNT_W-1:0] cnt_load_val, cnt_q;
  logic [CNT_W-1:0] start_len_c, start_sh_c;
  logic [WIDTH-1:0] start_pat_c;

  bit_cnt_311 u_cnt (
    .clk_311  (clk_311),
    .rst_311  (rst_311),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .cnt      (cnt_q),
    .last_c   (cnt_last_c)
  );

  // Align the requested pattern so bit L-1 lands in the MSB.
  always_comb begin
    start_len_c = eff_len(bus.len_311, WIDTH);
    start_sh_c  = CNT_W'(WIDTH) - start_len_c;
    start_pat_c = bus.data_311 << start_sh_c;
  end

  // Next-state and next-output decode.
  always_comb begin
    state_nxt    = state;
    pat_nxt      = pat_q;
    sr_nxt       = sr_q;
    len_nxt      = len_q;
    rep_nxt      = rep_q;
    out_nxt      = 1'b0;
    vld_nxt      = 1'b0;
    busy_nxt     = 1'b0;
    done_nxt     = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = len_q;
    cnt_dec      = 1'b0;

    case (state)
      ST_IDLE: begin
        if (bus.start_311) begin
          pat_nxt      = start_pat_c;
          sr_nxt       = start_pat_c << 1;
          len_nxt      = start_len_c;
          rep_nxt      = bus.rep_311;
          cnt_load     = 1'b1;
          cnt_load_val = start_len_c;
          out_nxt      = start_pat_c[WIDTH-1];
          vld_nxt      = 1'b1;
          busy_nxt     = 1'b1;
          state_nxt    = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (!cnt_last_c) begin
          cnt_dec  = 1'b1;
          out_nxt  = sr_q[WIDTH-1];
          sr_nxt   = sr_q << 1;
          vld_nxt  = 1'b1;
          busy_nxt = 1'b1;
        end else if (rep_q && bus.rep_311) begin
          cnt_load     = 1'b1;
          cnt_load_val = len_q;
          out_nxt      = pat_q[WIDTH-1];
          sr_nxt       = pat_q << 1;
          vld_nxt      = 1'b1;
          busy_nxt     = 1'b1;
        end else begin
          done_nxt  = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, capture and output registers.
  always_ff @(posedge clk_311) begin
    if (rst_311) begin
      state        <= ST_IDLE;
      pat_q        <= '0;
      sr_q         <= '0;
      len_q        <= '0;
      rep_q        <= 1'b0;
      bus.out_311  <= 1'b0;
      bus.vld_311  <= 1'b0;
      bus.busy_311 <= 1'b0;
      bus.done_311 <= 1'b0;
    end else begin
      state        <= state_nxt;
      pat_q        <= pat_nxt;
      sr_q         <= sr_nxt;
      len_q        <= len_nxt;
      rep_q        <= rep_nxt;
      bus.out_311  <= out_nxt;
      bus.vld_311  <= vld_nxt;
      bus.busy_311 <= busy_nxt;
      bus.done_311 <= done_nxt;
    end
  end

endmodule

// File: tb/tb_pattern_tx_311.sv
// Self-checking bench for pattern_tx_311 with a transaction-level reference.
module tb_pattern_tx_311;
  import pattern_pkg_311::*;

  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  logic exp_out  [64];
  logic exp_vld  [64];
  logic exp_busy [64];
  logic exp_done [64];

  logic [3:0] det_dut, det_exp;

  pattern_tx_311_if #(.WIDTH(W)) bus ();

  pattern_tx_311 #(.WIDTH(W)) dut (
    .clk_311 (clk),
    .rst_311 (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  function automatic int eff(input logic [3:0] len);
    return (len == 4'd0 || int'(len) > int'(W)) ? int'(W) : int'(len);
  endfunction

  // Expected per-cycle outputs for one transaction started at cycle 0.
  task automatic build_model(input logic [W-1:0] d, input logic [3:0] len,
                             input logic rc, input logic [63:0] rw,
                             input int rst_c, output int ncyc);
    int  l, t;
    bit  fin;
    for (int i = 0; i < 64; i++) begin
      exp_out[i] = 0; exp_vld[i] = 0; exp_busy[i] = 0; exp_done[i] = 0;
    end
    l = eff(len);
    t = 1;
    fin = 0;
    while (!fin) begin
      for (int i = l - 1; i >= 0; i--) begin
        exp_out[t] = d[i]; exp_vld[t] = 1; exp_busy[t] = 1; t++;
      end
      if (!(rc && rw[t-1])) begin
        exp_done[t] = 1; t++; fin = 1;
      end
    end
    if (rst_c >= 0) begin
      for (int i = rst_c + 1; i < 64; i++) begin
        exp_out[i] = 0; exp_vld[i] = 0; exp_busy[i] = 0; exp_done[i] = 0;
      end
      ncyc = rst_c + 3;
    end else begin
      ncyc = t + 2;
    end
  endtask

  task automatic check(input string tag, input int t);
    logic [3:0] nd, ne;
    logic       hd, he;
    total++;
    assert (bus.out_311 === exp_out[t]) else begin
      bad++; $error("FAIL %s c=%0d out obs=%b exp=%b", tag, t, bus.out_311, exp_out[t]);
    end
    total++;
    assert (bus.vld_311 === exp_vld[t]) else begin
      bad++; $error("FAIL %s c=%0d vld obs=%b exp=%b", tag, t, bus.vld_311, exp_vld[t]);
    end
    total++;
    assert (bus.busy_311 === exp_busy[t]) else begin
      bad++; $error("FAIL %s c=%0d busy obs=%b exp=%b", tag, t, bus.busy_311, exp_busy[t]);
    end
    total++;
    assert (bus.done_311 === exp_done[t]) else begin
      bad++; $error("FAIL %s c=%0d done obs=%b exp=%b", tag, t, bus.done_311, exp_done[t]);
    end
    // 1011 detector fed by the DUT stream versus one fed by the expected stream
    nd = {det_dut[2:0], bus.out_311};
    ne = {det_exp[2:0], exp_out[t]};
    hd = (bus.vld_311 === 1'b1) && (nd == 4'b1011);
    he = exp_vld[t] && (ne == 4'b1011);
    if (bus.vld_311 === 1'b1) det_dut = nd;
    if (exp_vld[t]) det_exp = ne;
    total++;
    assert (hd === he) else begin
      bad++; $error("FAIL %s c=%0d det obs=%b exp=%b", tag, t, hd, he);
    end
  endtask

  // Drive one transaction cycle by cycle and compare every output cycle.
  task automatic run(input string tag, input logic [W-1:0] d, input logic [3:0] len,
                     input logic rc, input logic [63:0] rw, input int rst_c,
                     input int xs_c, input logic [W-1:0] xd);
    int n;
    build_model(d, len, rc, rw, rst_c, n);
    det_dut = '0;
    det_exp = '0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      bus.start_311 = (c == 0) || (c == xs_c);
      bus.data_311  = (c == 0) ? d : xd;
      bus.len_311   = (c == 0) ? len : 4'($urandom);
      bus.rep_311   = (c == 0) ? rc : rw[c];
      rst           = (c == rst_c);
      @(posedge clk);
      #1;
      check(tag, c + 1);
    end
    @(negedge clk);
    bus.start_311 = 0; bus.rep_311 = 0; rst = 0;
  endtask

  initial begin
    logic [W-1:0] rd;
    logic [3:0]   rl;
    logic         rrc;
    logic [63:0]  rrw;
    int           rrst, rxs;

    rst = 1;
    bus.start_311 = 0; bus.data_311 = '0; bus.len_311 = '0; bus.rep_311 = 0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    assert ({bus.out_311, bus.vld_311, bus.busy_311, bus.done_311} === 4'b0000) else begin
      bad++; $error("FAIL reset obs=%b exp=0000",
                    {bus.out_311, bus.vld_311, bus.busy_311, bus.done_311});
    end

    run("basic",    8'h0B, 4'd4,  1'b0, 64'h0,   -1, -1, 8'h00);
    run("clamp0",   8'hA5, 4'd0,  1'b0, 64'h0,   -1, -1, 8'h00);
    run("clamp12",  8'hA5, 4'd12, 1'b0, 64'h0,   -1, -1, 8'h00);
    run("repeat",   8'h05, 4'd3,  1'b1, 64'h7F,  -1, -1, 8'h00);
    run("busystart",8'h0B, 4'd4,  1'b0, 64'h0,   -1,  2, 8'hF0);
    run("donestart",8'h0B, 4'd4,  1'b0, 64'h0,   -1,  5, 8'hFF);
    run("rstmid",   8'h0B, 4'd4,  1'b0, 64'h0,    2, -1, 8'h00);
    run("rststart", 8'h0B, 4'd4,  1'b0, 64'h0,    0, -1, 8'h00);
    run("afterrst", 8'h3C, 4'd6,  1'b0, 64'h0,   -1, -1, 8'h00);
    run("loopback", 8'h0B, 4'd4,  1'b1, 64'hFFF, -1, -1, 8'h00);

    for (int k = 0; k < 25; k++) begin
      rd   = W'($urandom);
      rl   = 4'($urandom_range(0, 15));
      rrc  = 1'($urandom_range(0, 1));
      rrw  = {32'($urandom), 32'($urandom)} & 64'h0000_00FF_FFFF_FFFF;
      rrst = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 10)) : -1;
      rxs  = (rrst < 0) ? int'($urandom_range(1, eff(rl))) : -1;
      run("random", rd, rl, rrc, rrw, rrst, rxs, W'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
